legv8_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the LEGv8 CPU's instruction-fetch (IF) and data (DM) requesters.

---
 rtl/legv8_arb_pkg.sv | 18 +
 rtl/legv8_arb_pick.sv | 64 ++++++
 rtl/legv8_mem_arbiter.sv | 119 +++++++++++
 tb/tb_legv8_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_arb_pkg.sv
// Shared types for the LEGv8 unified-memory arbiter: FSM states, requester owner, latency bound.
package legv8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_t;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/legv8_arb_pick.sv
// Winner select between fetch and data requesters. Default: DM priority with an IF starvation guard;
// LEGV8_ARB_ROUND_ROBIN_EN switches ties to alternate against the last grant.
module legv8_arb_pick
  import legv8_arb_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   if_valid,
  input  logic   dm_valid,
  input  logic   if_grant,
  input  logic   dm_grant,
  output owner_t winner
);

`ifdef LEGV8_ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  // Reset to IF so the first tie after reset goes to DM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWNER_IF;
    end else if (dm_grant) begin
      last_grant <= OWNER_DM;
    end else if (if_grant) begin
      last_grant <= OWNER_IF;
    end
  end

  always_comb begin
    winner = OWNER_IF;
    if (dm_valid && !(if_valid && (last_grant == OWNER_DM))) begin
      winner = OWNER_DM;
    end
  end
`else
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [SW-1:0] starve;
  logic          force_if;

  // Counts DM grants taken while IF was waiting; any idle IF cycle forgives the debt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
    end else if (dm_grant && if_valid) begin
      starve <= starve + 1'b1;
    end else if (if_grant || !if_valid) begin
      starve <= '0;
    end
  end

  assign force_if = (starve >= SW'(MAX_STARVE));

  always_comb begin
    winner = OWNER_IF;
    if (dm_valid && !(if_valid && force_if)) begin
      winner = OWNER_DM;
    end
  end
`endif

endmodule

// File: rtl/legv8_mem_arbiter.sv
// Single-port memory arbiter for LEGv8 fetch and data paths: one access in flight, fixed read latency.
// Arbitration policy selected by LEGV8_ARB_ROUND_ROBIN_EN (undefined: DM priority with starvation guard).
module legv8_mem_arbiter
  import legv8_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic              dm_req_write,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_t            dbg_state
);

  // Handshake: a request transfers on the rising edge where VALID and READY are both high.
  // READY is offered only in IDLE and only to the arbitration winner; VALID may drop freely.

  state_t           state;
  owner_t           owner;
  owner_t           winner;
  logic             is_write;
  logic [CNT_W-1:0] cnt;
  logic             accept_if;
  logic             accept_dm;

  legv8_arb_pick #(
    .MAX_STARVE(MAX_STARVE)
  ) u_pick (
    .clock    (clock),
    .reset_n  (reset_n),
    .if_valid (if_req_valid),
    .dm_valid (dm_req_valid),
    .if_grant (accept_if),
    .dm_grant (accept_dm),
    .winner   (winner)
  );

  assign if_req_ready = (state == IDLE) && if_req_valid && (winner == OWNER_IF);
  assign dm_req_ready = (state == IDLE) && dm_req_valid && (winner == OWNER_DM);
  assign accept_if    = if_req_valid && if_req_ready;
  assign accept_dm    = dm_req_valid && dm_req_ready;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWNER_IF;
      is_write     <= 1'b0;
      cnt          <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      dm_rsp_valid <= 1'b0;
      dm_rsp_data  <= '0;
    end else begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_if || accept_dm) begin
            owner     <= accept_dm ? OWNER_DM : OWNER_IF;
            is_write  <= accept_dm && dm_req_write;
            mem_addr  <= accept_dm ? dm_req_addr : if_req_addr;
            mem_wdata <= (accept_dm && dm_req_write) ? dm_req_wdata : '0;
            mem_en    <= 1'b1;
            mem_we    <= accept_dm && dm_req_write;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          // Final wait cycle is exactly when the memory presents read data.
          if (cnt == '0) begin
            state <= IDLE;
            if (owner == OWNER_DM) begin
              dm_rsp_valid <= 1'b1;
              dm_rsp_data  <= is_write ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// Randomized scoreboard bench for legv8_mem_arbiter with a memory model and a request-level reference.
module tb_legv8_mem_arbiter;
  import legv8_arb_pkg::*;

  localparam int MEM_LAT    = 2;
  localparam int MAX_STARVE = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        dm_req_valid, dm_req_write, dm_req_ready, dm_rsp_valid;
  logic [63:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
  logic        mem_en, mem_we, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dbg_state;

  legv8_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_write(dm_req_write),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  typedef struct packed { int due; logic own; logic [63:0] data; } rsp_t;
  typedef struct packed { int due; logic we; logic [63:0] addr; logic [63:0] wdata; } acc_t;
  typedef struct packed { int due; logic [63:0] data; } pend_t;

  rsp_t        exp_q[$];
  acc_t        acc_q[$];
  pend_t       pend_q[$];
  logic        grant_log[$];
  logic [63:0] ref_mem  [logic [63:0]];
  logic [63:0] phys_mem [logic [63:0]];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   free_cycle = 0;
  int   starve = 0;
  logic last_dm = 1'b0;
  logic grant_rec = 1'b0;
  logic [63:0] last_if_data = '0;
  logic [63:0] last_dm_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0] + 32'h1357};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [63:0] phys_rd(input logic [63:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : pat(a);
  endfunction

  // ---------------- monitor / scoreboard / memory model ----------------
  initial begin
    logic iv, dv, idle, dm_win, exp_ifr, exp_dmr, we;
    rsp_t e;
    acc_t a;
    forever begin
      @(negedge clock);
      #2;
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        acc_q.delete();
        pend_q.delete();
        free_cycle   = cyc + 1;
        starve       = 0;
        last_dm      = 1'b0;
        last_if_data = '0;
        last_dm_data = '0;
        mem_rdata    = {$urandom, $urandom};
      end else begin
        // responses
        chk("rsp_excl", {63'b0, if_rsp_valid & dm_rsp_valid}, 64'd0);
        if (if_rsp_valid || dm_rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", {63'b0, if_rsp_valid | dm_rsp_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_cycle", cyc, e.due);
            chk("rsp_owner", {63'b0, dm_rsp_valid}, {63'b0, e.own});
            if (e.own) begin
              chk("dm_rsp_data", dm_rsp_data, e.data);
              last_dm_data = e.data;
            end else begin
              chk("if_rsp_data", if_rsp_data, e.data);
              last_if_data = e.data;
            end
          end
        end else begin
          while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("rsp_missing", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
          end
        end
        if (!if_rsp_valid) chk("if_rsp_hold", if_rsp_data, last_if_data);
        if (!dm_rsp_valid) chk("dm_rsp_hold", dm_rsp_data, last_dm_data);

        // memory port and memory model
        if (mem_en) begin
          if (acc_q.size() == 0) begin
            chk("mem_en_spurious", {63'b0, mem_en}, 64'd0);
          end else begin
            a = acc_q.pop_front();
            chk("mem_en_cycle", cyc, a.due);
            chk("mem_we", {63'b0, mem_we}, {63'b0, a.we});
            chk("mem_addr", mem_addr, a.addr);
            if (a.we) chk("mem_wdata", mem_wdata, a.wdata);
          end
          if (mem_we) phys_mem[mem_addr] = mem_wdata;
          else        pend_q.push_back('{due: cyc + MEM_LAT, data: phys_rd(mem_addr)});
        end else begin
          chk("mem_we_idle", {63'b0, mem_we}, 64'd0);
          while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
            chk("mem_en_missing", cyc, acc_q[0].due);
            void'(acc_q.pop_front());
          end
        end

        // arbitration reference
        iv   = if_req_valid;
        dv   = dm_req_valid;
        idle = (cyc >= free_cycle);
`ifdef LEGV8_ARB_ROUND_ROBIN_EN
        dm_win = dv && !(iv && last_dm);
`else
        dm_win = dv && !(iv && (starve >= MAX_STARVE));
`endif
        exp_ifr = idle && iv && !dm_win;
        exp_dmr = idle && dm_win;
        chk("if_req_ready", {63'b0, if_req_ready}, {63'b0, exp_ifr});
        chk("dm_req_ready", {63'b0, dm_req_ready}, {63'b0, exp_dmr});
        chk("busy", {63'b0, busy}, {63'b0, !idle});
        if (grant_rec) begin
          if (dm_req_ready && dv)      grant_log.push_back(1'b1);
          else if (if_req_ready && iv) grant_log.push_back(1'b0);
        end

        if (exp_ifr || exp_dmr) begin
          we = exp_dmr && dm_req_write;
          if (exp_dmr) begin
            exp_q.push_back('{due: cyc + 2 + MEM_LAT, own: 1'b1,
                              data: we ? 64'd0 : ref_rd(dm_req_addr)});
            acc_q.push_back('{due: cyc + 1, we: we, addr: dm_req_addr, wdata: dm_req_wdata});
            if (we) ref_mem[dm_req_addr] = dm_req_wdata;
          end else begin
            exp_q.push_back('{due: cyc + 2 + MEM_LAT, own: 1'b0, data: ref_rd(if_req_addr)});
            acc_q.push_back('{due: cyc + 1, we: 1'b0, addr: if_req_addr, wdata: 64'd0});
          end
          free_cycle = cyc + 2 + MEM_LAT;
          last_dm    = exp_dmr;
        end
        if (exp_dmr && iv)          starve++;
        else if (exp_ifr || !iv)    starve = 0;

        if (pend_q.size() > 0 && pend_q[0].due == cyc) mem_rdata = pend_q.pop_front().data;
        else                                           mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [63:0] ia, input logic dv,
                       input logic [63:0] da, input logic dw, input logic [63:0] dwd);
    @(negedge clock);
    #1;
    if_req_valid = iv;
    if_req_addr  = ia;
    dm_req_valid = dv;
    dm_req_addr  = da;
    dm_req_write = dw;
    dm_req_wdata = dwd;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 3) != 0, 64'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, 64'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), {$urandom, $urandom});
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset_n      = 1'b0;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    dm_req_write = 1'b0;
    #1;
    chk("rst_mem_en", {63'b0, mem_en}, 64'd0);
    chk("rst_if_rsp_valid", {63'b0, if_rsp_valid}, 64'd0);
    chk("rst_dm_rsp_valid", {63'b0, dm_rsp_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic exp_g;
    reset_n      = 1'b0;
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    dm_req_valid = 1'b0;
    dm_req_addr  = '0;
    dm_req_write = 1'b0;
    dm_req_wdata = '0;
    mem_rdata    = '0;
    ref_mem[64'h10]  = 64'hF840_1142;
    phys_mem[64'h10] = 64'hF840_1142;

    repeat (3) @(negedge clock);
    #1;
    chk("init_mem_en", {63'b0, mem_en}, 64'd0);
    chk("init_mem_we", {63'b0, mem_we}, 64'd0);
    chk("init_mem_addr", mem_addr, 64'd0);
    chk("init_mem_wdata", mem_wdata, 64'd0);
    chk("init_if_rsp", {63'b0, if_rsp_valid}, 64'd0);
    chk("init_dm_rsp", {63'b0, dm_rsp_valid}, 64'd0);
    chk("init_if_data", if_rsp_data, 64'd0);
    chk("init_dm_data", dm_rsp_data, 64'd0);
    chk("init_busy", {63'b0, busy}, 64'd0);
    reset_n = 1'b1;

    idle_cycles(2);
    drive(1'b1, 64'h10, 1'b0, 64'd0, 1'b0, 64'd0);
    idle_cycles(6);
    drive(1'b0, 64'd0, 1'b1, 64'd11, 1'b1, 64'd2117);
    idle_cycles(6);
    drive(1'b0, 64'd0, 1'b1, 64'd11, 1'b0, 64'd0);
    idle_cycles(6);
    drive(1'b1, 64'h20, 1'b1, 64'd5, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h20, 1'b0, 64'd0, 1'b0, 64'd0);
    idle_cycles(6);

    do_reset();
    grant_rec = 1'b1;
    for (int i = 0; i < 44; i++)
      drive(1'b1, 64'($urandom_range(0, 15)), 1'b1, 64'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), {$urandom, $urandom});
    grant_rec = 1'b0;
    idle_cycles(6);
    for (int i = 0; i < 10; i++) begin
`ifdef LEGV8_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0);
`else
      exp_g = (i % 5 != 4);
`endif
      if (i < grant_log.size()) chk("grant_seq", {63'b0, grant_log[i]}, {63'b0, exp_g});
      else                      chk("grant_count", grant_log.size(), 10);
    end

    rand_cycles(1500);

    idle_cycles(8);
    drive(1'b1, 64'h10, 1'b0, 64'd0, 1'b0, 64'd0);
    idle_cycles(2);
    do_reset();
    idle_cycles(8);

    rand_cycles(500);

    for (int i = 0; i < 40 && (exp_q.size() > 0 || acc_q.size() > 0); i++) idle_cycles(1);
    chk("drain_rsp_left", exp_q.size(), 0);
    chk("drain_acc_left", acc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
